// File: rtl/aurora_link_pkg.sv
// Shared definitions for the Aurora link bring-up controller.
// Latency: none (types and constants only).
// Backpressure: none.
package aurora_link_pkg;

  // State encoding; RETRY is a decision taken on the way out of
  // WAIT_UP/LINKED and never occupies a cycle, so it has no code.
  typedef enum logic [2:0] {
    PMA_ASSERT = 3'd0,
    PB_HOLD    = 3'd1,
    WAIT_UP    = 3'd2,
    LINKED     = 3'd3,
    FAILED     = 3'd4
  } state_t;

  localparam int RETRY_W = 8;

endpackage

// File: rtl/aurora_link_ctrl_if.sv
// Core-side and status signals between the link controller and its neighbours.
// Latency: none (wiring only).
// Backpressure: none; all signals are levels.
interface aurora_link_ctrl_if #(
  parameter int NUM_LANES = 4
);
  import aurora_link_pkg::*;

  // from the Aurora core (user_clk domain, asynchronous to init_clk)
  logic                 channel_up;
  logic [NUM_LANES-1:0] lane_up;
  logic                 hard_err;

  // to the Aurora core
  logic                 pma_init;
  logic                 reset_pb;

  // status toward the kernel/host
  logic                 link_ready;
  logic                 link_failed;
  logic [RETRY_W-1:0]   retry_count;
  logic [NUM_LANES-1:0] lane_up_sync;
  logic [2:0]           state_dbg;

  modport master (
    input  channel_up, lane_up, hard_err,
    output pma_init, reset_pb, link_ready, link_failed,
           retry_count, lane_up_sync, state_dbg
  );

  modport slave (
    output channel_up, lane_up, hard_err,
    input  pma_init, reset_pb, link_ready, link_failed,
           retry_count, lane_up_sync, state_dbg
  );

endinterface

// File: rtl/aurora_link_ctrl_sync_2ff.sv
// Two-flop synchronizer bank for independent asynchronous level inputs.
// Latency: 2 clk cycles from a stable input to dout.
// Backpressure: none; bits are synchronized independently (no bus coherency).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // first stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/aurora_link_ctrl.sv
// Sequences pma_init/reset_pb for an Aurora core, supervises the link, retries boundedly.
// Latency: 2 cycles input sync + 1 cycle to state change; outputs decoded from state register.
// Backpressure: none; inputs are sampled levels, restart is a single-cycle request.
module aurora_link_ctrl
  import aurora_link_pkg::*;
#(
  parameter int NUM_LANES         = 4,
  parameter int PMA_INIT_CYCLES   = 100_000_000,
  parameter int PB_HOLD_CYCLES    = 128,
  parameter int UP_TIMEOUT_CYCLES = 200_000_000,
  parameter int DROP_FILTER       = 16,
  parameter int MAX_RETRIES       = 7
) (
  input  logic           init_clk,
  input  logic           reset,
  input  logic           restart,
  aurora_link_ctrl_if.master link
);

  localparam int SYNC_W = NUM_LANES + 2;
  localparam int DROP_W = $clog2(DROP_FILTER + 1);

  localparam logic [31:0]        PMA_LAST  = 32'(PMA_INIT_CYCLES - 1);
  localparam logic [31:0]        PB_LAST   = 32'(PB_HOLD_CYCLES - 1);
  localparam logic [31:0]        UP_LAST   = 32'(UP_TIMEOUT_CYCLES - 1);
  localparam logic [DROP_W-1:0]  DROP_LAST = DROP_W'(DROP_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic [SYNC_W-1:0]    sync_in;
  logic [SYNC_W-1:0]    sync_out;
  logic                 hard_err_s;
  logic                 channel_up_s;
  logic [NUM_LANES-1:0] lane_up_s;
  logic                 link_ok;

  state_t               state, state_next;
  logic [31:0]          cnt, cnt_next;
  logic [DROP_W-1:0]    drop_cnt, drop_next;
  logic [RETRY_W-1:0]   retry_count, retry_next;
  logic                 do_retry;

  assign sync_in = {link.hard_err, link.channel_up, link.lane_up};

  sync_2ff #(.WIDTH(SYNC_W)) u_sync (
    .clk   (init_clk),
    .reset (reset),
    .din   (sync_in),
    .dout  (sync_out)
  );

  assign {hard_err_s, channel_up_s, lane_up_s} = sync_out;
  assign link_ok = channel_up_s & (&lane_up_s);

  // state, dwell counter, drop filter and retry counter registers
  always_ff @(posedge init_clk) begin
    if (reset) begin
      state       <= PMA_ASSERT;
      cnt         <= '0;
      drop_cnt    <= '0;
      retry_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      drop_cnt    <= drop_next;
      retry_count <= retry_next;
    end
  end

  // next-state logic; the retry decision resolves in the same cycle as its trigger
  always_comb begin
    state_next = state;
    retry_next = retry_count;
    drop_next  = '0;
    do_retry   = 1'b0;
    cnt_next   = cnt + 32'd1;

    case (state)
      PMA_ASSERT: if (cnt == PMA_LAST) state_next = PB_HOLD;
      PB_HOLD:    if (cnt == PB_LAST)  state_next = WAIT_UP;
      WAIT_UP: begin
        if (link_ok)              state_next = LINKED;
        else if (cnt == UP_LAST)  do_retry   = 1'b1;
      end
      LINKED: begin
        // hard errors only matter once the link has been declared up
        if (hard_err_s) begin
          do_retry = 1'b1;
        end else if (!link_ok) begin
          if (drop_cnt == DROP_LAST) do_retry  = 1'b1;
          else                       drop_next = drop_cnt + DROP_W'(1);
        end
      end
      FAILED:  state_next = FAILED;
      default: state_next = PMA_ASSERT;
    endcase

    // retry_count saturates at the limit; hitting it parks the link in FAILED
    if (do_retry) begin
      if (retry_count == RETRY_MAX) begin
        state_next = FAILED;
      end else begin
        retry_next = retry_count + RETRY_W'(1);
        state_next = PMA_ASSERT;
      end
    end

    if (restart) begin
      state_next = PMA_ASSERT;
      retry_next = '0;
      drop_next  = '0;
    end

    // every state entry (including restart into PMA_ASSERT) restarts the dwell count
    if (restart || (state_next != state)) cnt_next = '0;
  end

  // Moore output decode from the registered state
  always_comb begin
    link.pma_init    = 1'b0;
    link.reset_pb    = 1'b0;
    link.link_ready  = 1'b0;
    link.link_failed = 1'b0;
    case (state)
      PMA_ASSERT: begin
        link.pma_init = 1'b1;
        link.reset_pb = 1'b1;
      end
      PB_HOLD: link.reset_pb = 1'b1;
      LINKED:  link.link_ready = 1'b1;
      FAILED: begin
        link.pma_init    = 1'b1;
        link.reset_pb    = 1'b1;
        link.link_failed = 1'b1;
      end
      default: link.link_ready = 1'b0;
    endcase
  end

  assign link.retry_count  = retry_count;
  assign link.lane_up_sync = lane_up_s;
  assign link.state_dbg    = state;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Scoreboard bench for aurora_link_ctrl: stimulus pushes expected status, a monitor checks it.
// Latency: expectations are tagged with the cycle (relative to reset release) they apply to.
// Backpressure: none.
module tb_aurora_link_ctrl;
  import aurora_link_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       pma;
    logic       pb;
    logic       rdy;
    logic       fl;
    logic [7:0] rc;
    logic [3:0] lus;
  } obs_t;

  typedef struct {
    int    at;
    string name;
    obs_t  want;
  } exp_t;

  logic clk;
  logic reset;
  logic restart;
  int   cyc;
  int   base;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  aurora_link_ctrl_if #(.NUM_LANES(4)) link_if ();

  aurora_link_ctrl #(
    .NUM_LANES         (4),
    .PMA_INIT_CYCLES   (8),
    .PB_HOLD_CYCLES    (4),
    .UP_TIMEOUT_CYCLES (32),
    .DROP_FILTER       (3),
    .MAX_RETRIES       (2)
  ) dut (
    .init_clk (clk),
    .reset    (reset),
    .restart  (restart),
    .link     (link_if.master)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // global edge counter used to time both stimulus and checks
  always @(posedge clk) cyc <= cyc + 1;

  // safety net in case the run stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  // expected pin levels per state, straight from the state table
  function automatic obs_t mk(input state_t st, input int rc, input logic [3:0] lus);
    obs_t o;
    o.st  = st;
    o.pma = (st == PMA_ASSERT) || (st == FAILED);
    o.pb  = (st == PMA_ASSERT) || (st == PB_HOLD) || (st == FAILED);
    o.rdy = (st == LINKED);
    o.fl  = (st == FAILED);
    o.rc  = 8'(rc);
    o.lus = lus;
    return o;
  endfunction

  task automatic expect_at(input int k, input string name, input state_t st,
                           input int rc, input logic [3:0] lus);
    exp_t e;
    e.at   = base + k;
    e.name = name;
    e.want = mk(st, rc, lus);
    sb.push_back(e);
  endtask

  // advance to cycle k (relative to base), landing just after its rising edge
  task automatic at_cycle(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    base  = cyc;
  endtask

  // monitor: compare queued expectations when their cycle arrives
  always @(negedge clk) begin
    exp_t e;
    obs_t got;
    got.st  = link_if.state_dbg;
    got.pma = link_if.pma_init;
    got.pb  = link_if.reset_pb;
    got.rdy = link_if.link_ready;
    got.fl  = link_if.link_failed;
    got.rc  = link_if.retry_count;
    got.lus = link_if.lane_up_sync;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp = n_cmp + 1;
      if (e.at != cyc || got !== e.want) begin
        n_bad = n_bad + 1;
        $display("FAIL %s @%0d: got st=%0d pma=%b pb=%b rdy=%b fl=%b rc=%0d lus=%h, want st=%0d pma=%b pb=%b rdy=%b fl=%b rc=%0d lus=%h",
                 e.name, cyc - base, got.st, got.pma, got.pb, got.rdy, got.fl, got.rc, got.lus,
                 e.want.st, e.want.pma, e.want.pb, e.want.rdy, e.want.fl, e.want.rc, e.want.lus);
      end
    end
  end

  // directed stimulus
  initial begin
    cyc     = 0;
    base    = 0;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    restart = 1'b0;
    link_if.channel_up = 1'b1;
    link_if.lane_up    = 4'hF;
    link_if.hard_err   = 1'b0;

    // normal bring-up
    do_reset();
    expect_at(0,  "a_rst",      PMA_ASSERT, 0, 4'h0);
    expect_at(1,  "a_sync1",    PMA_ASSERT, 0, 4'h0);
    expect_at(2,  "a_sync2",    PMA_ASSERT, 0, 4'hF);
    expect_at(7,  "a_pma_end",  PMA_ASSERT, 0, 4'hF);
    expect_at(8,  "a_pb",       PB_HOLD,    0, 4'hF);
    expect_at(11, "a_pb_end",   PB_HOLD,    0, 4'hF);
    expect_at(12, "a_wait",     WAIT_UP,    0, 4'hF);
    expect_at(13, "a_linked",   LINKED,     0, 4'hF);
    expect_at(20, "a_hold",     LINKED,     0, 4'hF);

    // lane 2 drops for 2 cycles: filtered out
    at_cycle(21);
    link_if.lane_up = 4'hB;
    expect_at(23, "drop2_a",  LINKED, 0, 4'hB);
    expect_at(24, "drop2_b",  LINKED, 0, 4'hB);
    expect_at(26, "drop2_ok", LINKED, 0, 4'hF);
    at_cycle(23);
    link_if.lane_up = 4'hF;

    // lane 2 drops for 3 cycles: retry
    at_cycle(30);
    link_if.lane_up = 4'hB;
    expect_at(34, "drop3_last",  LINKED,     0, 4'hB);
    expect_at(35, "drop3_retry", PMA_ASSERT, 1, 4'hF);
    expect_at(42, "a_re_pma_end", PMA_ASSERT, 1, 4'hF);
    expect_at(43, "a_re_pb",     PB_HOLD,    1, 4'hF);
    expect_at(47, "a_re_wait",   WAIT_UP,    1, 4'hF);
    expect_at(48, "a_re_linked", LINKED,     1, 4'hF);
    at_cycle(33);
    link_if.lane_up = 4'hF;

    // single-cycle hard error pulse while linked
    at_cycle(50);
    link_if.hard_err = 1'b1;
    expect_at(52, "herr_pre", LINKED,     1, 4'hF);
    expect_at(53, "herr_pma", PMA_ASSERT, 2, 4'hF);
    at_cycle(51);
    link_if.hard_err = 1'b0;

    // link never comes up: two retries then FAILED
    at_cycle(55);
    link_if.channel_up = 1'b0;
    do_reset();
    expect_at(0,   "b_rst",     PMA_ASSERT, 0, 4'h0);
    expect_at(43,  "b_to1",     WAIT_UP,    0, 4'hF);
    expect_at(44,  "b_retry1",  PMA_ASSERT, 1, 4'hF);
    expect_at(87,  "b_to2",     WAIT_UP,    1, 4'hF);
    expect_at(88,  "b_retry2",  PMA_ASSERT, 2, 4'hF);
    expect_at(131, "b_to3",     WAIT_UP,    2, 4'hF);
    expect_at(132, "b_failed",  FAILED,     2, 4'hF);
    // hard_err during WAIT_UP must be ignored
    at_cycle(20);
    link_if.hard_err = 1'b1;
    at_cycle(25);
    link_if.hard_err = 1'b0;
    // hard_err during FAILED must be ignored too
    at_cycle(150);
    link_if.hard_err = 1'b1;
    expect_at(170, "b_fail_hold",  FAILED, 2, 4'hF);
    expect_at(200, "b_fail_hold2", FAILED, 2, 4'hF);
    at_cycle(160);
    link_if.hard_err = 1'b0;

    // restart out of FAILED with the link present
    at_cycle(201);
    link_if.channel_up = 1'b1;
    at_cycle(205);
    restart = 1'b1;
    expect_at(205, "c_pre",      FAILED,     2, 4'hF);
    expect_at(206, "c_restart",  PMA_ASSERT, 0, 4'hF);
    expect_at(213, "c_pma_end",  PMA_ASSERT, 0, 4'hF);
    expect_at(214, "c_pb",       PB_HOLD,    0, 4'hF);
    expect_at(218, "c_wait",     WAIT_UP,    0, 4'hF);
    expect_at(219, "c_linked",   LINKED,     0, 4'hF);
    at_cycle(206);
    restart = 1'b0;
    at_cycle(225);
    link_if.hard_err = 1'b1;
    expect_at(228, "c_herr", PMA_ASSERT, 1, 4'hF);
    at_cycle(226);
    link_if.hard_err = 1'b0;

    // reset while retry_count is nonzero, then reset during PB_HOLD
    at_cycle(230);
    do_reset();
    expect_at(0, "d_rst", PMA_ASSERT, 0, 4'h0);
    expect_at(8, "d_pb",  PB_HOLD,    0, 4'hF);
    at_cycle(9);
    reset = 1'b1;
    expect_at(10, "d_rst_mid",   PMA_ASSERT, 0, 4'h0);
    expect_at(11, "d_rst_mid1",  PMA_ASSERT, 0, 4'h0);
    expect_at(17, "d_pma_end",   PMA_ASSERT, 0, 4'hF);
    expect_at(18, "d_pb2",       PB_HOLD,    0, 4'hF);
    expect_at(21, "d_pb2_end",   PB_HOLD,    0, 4'hF);
    expect_at(22, "d_wait",      WAIT_UP,    0, 4'hF);
    expect_at(23, "d_linked",    LINKED,     0, 4'hF);
    at_cycle(10);
    reset = 1'b0;

    // reset and restart together: reset wins (sync flops cleared too)
    at_cycle(30);
    reset   = 1'b1;
    restart = 1'b1;
    expect_at(31, "d_rr",         PMA_ASSERT, 0, 4'h0);
    expect_at(38, "d_rr_pma_end", PMA_ASSERT, 0, 4'hF);
    expect_at(39, "d_rr_pb",      PB_HOLD,    0, 4'hF);
    at_cycle(31);
    reset   = 1'b0;
    restart = 1'b0;

    at_cycle(42);
    if (sb.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: %0d expectations never checked, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
